prog_loader: RTL

Instruction-memory writer for the 16-bit CPU: receives a framed byte stream over a valid/ready handshake, assembles 16-bit words high byte first, and writes them to consecutive addresses of the instruction RAM write port. It is the counterpart of the CPU's program-counter fetch path. It holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_csum.sv | 41 ++++
 rtl/prog_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the instruction-memory loader.
//   WORD_BYTES : bytes per instruction word. The stream sends the high byte
//                first.
//   state_t    : loader FSM states, ST_IDLE .. ST_ERROR.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    localparam int WORD_BYTES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/prog_loader_csum.sv
// -----------------------------------------------------------------------------
// loader_csum
// XOR checksum accumulator for the loader's data bytes.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr_i      : zero the accumulator. It takes priority over en_i.
//   en_i       : XOR byte_i into the accumulator
//   byte_i     : data byte
//   csum_o     : current accumulator value (registered)
// -----------------------------------------------------------------------------
module loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] csum_o
);

    logic [7:0] csum_q;
    logic [7:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr_i) begin
            csum_d = 8'h00;
        end else if (en_i) begin
            csum_d = csum_q ^ byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a framed byte stream and writes it into instruction RAM port B.
// The CPU is held in reset until a checksum-verified image has been written.
// Frame layout:
//   LEN_HI, LEN_LO        word count N (big-endian)
//   N x (HI, LO)          instruction words
//   CHK                   XOR of all data bytes
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start_i      start (or restart) a load
//   in_byte_i    stream byte
//   in_valid_i   stream valid
//   in_ready_o   ready to accept a byte (combinational from the state)
//   ram_addr_o   RAM write address
//   ram_data_o   RAM write data
//   ram_we_o     RAM write enable, one pulse per word
//   cpu_run_o    1 releases the CPU from reset
//   busy_o       a load is in progress
//   done_o       the last load succeeded (sticky)
//   err_o        the last load failed (sticky)
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        in_byte_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    output logic              cpu_run_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int BYTE_W = DATA_W / WORD_BYTES;
    // The word count may equal the full capacity, so one extra bit is needed.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state_q,   state_d;
    logic [ADDR_W:0]   cnt_q,     cnt_d;
    logic [15:0]       len_q,     len_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              we_q,      we_d;
    logic              run_q,     run_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   cnt_inc;
    logic [7:0]        csum;
    logic              csum_en;

    assign in_ready_o = (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
                                         ST_DATA_LO, ST_CHECK});
    assign accept     = in_valid_i && in_ready_o;
    assign len_full   = {len_q[15:8], in_byte_i};
    assign cnt_inc    = cnt_q + 1'b1;

    // A Start that coincides with an accepted byte drops the byte, so the
    // byte must not reach the checksum.
    assign csum_en = accept && !start_i &&
                     ((state_q == ST_DATA_HI) || (state_q == ST_DATA_LO));

    loader_csum u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_i),
        .en_i   (csum_en),
        .byte_i (in_byte_i),
        .csum_o (csum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        run_d   = run_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        if (start_i) begin
            state_d = ST_LEN_HI;
            cnt_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            run_d   = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_LEN_HI: begin
                    if (accept) begin
                        len_d[15:8] = in_byte_i;
                        state_d     = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_d = len_full;
                        if ({1'b0, len_full} > MAX_WORDS) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else if (len_full == 16'd0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (accept) begin
                        data_d[DATA_W-1 -: BYTE_W] = in_byte_i;
                        state_d = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (accept) begin
                        // Address, data and enable are registered together,
                        // so they are stable for the whole WRITE cycle.
                        data_d[BYTE_W-1:0] = in_byte_i;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        we_d    = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    cnt_d = cnt_inc;
                    if (16'(cnt_inc) == len_q) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        busy_d = 1'b0;
                        if (in_byte_i == csum) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            run_d   = 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERROR: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ram_addr_o = addr_q;
    assign ram_data_o = data_q;
    assign ram_we_o   = we_q;
    assign cpu_run_o  = run_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
